// File: rtl/mp64_extbridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : mp64_extbridge_if
//  Description : Handshake bundle for mp64_extbridge. Carries the held ext_*
//                request/ack channel from the memory subsystem and the 32-bit
//                valid/ready peripheral bus (pbus).
//                master : bridge side. It consumes ext requests, returns the
//                         ack and read data, and drives the pbus beats.
//                slave  : environment side. It drives ext requests and acts
//                         as the pbus responder.
//  Revision    : 1.0  initial release
// ============================================================================
interface mp64_extbridge_if;
    // ext request/ack channel
    logic        ext_req;
    logic [63:0] ext_addr;
    logic [63:0] ext_wdata;
    logic        ext_wen;
    logic [1:0]  ext_size;
    logic [63:0] ext_rdata;
    logic        ext_ack;
    // peripheral bus
    logic        pb_valid;
    logic [31:0] pb_addr;
    logic        pb_write;
    logic [31:0] pb_wdata;
    logic [3:0]  pb_wstrb;
    logic        pb_ready;
    logic [31:0] pb_rdata;
    logic        pb_err;

    modport master (
        input  ext_req, ext_addr, ext_wdata, ext_wen, ext_size,
        input  pb_ready, pb_rdata, pb_err,
        output ext_rdata, ext_ack,
        output pb_valid, pb_addr, pb_write, pb_wdata, pb_wstrb
    );

    modport slave (
        output ext_req, ext_addr, ext_wdata, ext_wen, ext_size,
        output pb_ready, pb_rdata, pb_err,
        input  ext_rdata, ext_ack,
        input  pb_valid, pb_addr, pb_write, pb_wdata, pb_wstrb
    );
endinterface
`default_nettype wire

// File: rtl/mp64_extbridge.sv
`default_nettype none
// ============================================================================
//  Module      : mp64_extbridge
//  Description : Turns each held 64-bit ext request into one beat (byte, half
//                or word) or two beats (dword) on the 32-bit pbus. Checks
//                alignment, aborts any beat that waits too long for pb_ready,
//                and captures the address of the first failing request.
//  Ports       : clk, rst_n (async, active low)
//                bus      - mp64_extbridge_if.master (ext_* and pb_* signals)
//                err_clr  - synchronous clear of the error capture
//                err_flag - sticky error indicator
//                err_addr - ext_addr of the first errored request
//  Revision    : 1.0  initial release
// ============================================================================
module mp64_extbridge #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [63:0] ERR_RDATA      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mp64_extbridge_if.master bus,
    input  wire logic        err_clr,
    output logic             err_flag,
    output logic [63:0]      err_addr
);

    localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_BEAT0 = 3'd2,
        S_BEAT1 = 3'd3,
        S_RESP  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t      r_state;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic        r_wen;
    logic [1:0]  r_size;
    logic [31:0] r_rdata_lo;     // dword beat0 read data, held for beat1
    logic [15:0] r_tmo;
    logic        r_pb_valid;
    logic [31:0] r_pb_addr;
    logic        r_pb_write;
    logic [31:0] r_pb_wdata;
    logic [3:0]  r_pb_wstrb;
    logic        r_ext_ack;
    logic [63:0] r_ext_rdata;
    logic        r_err_flag;
    logic [63:0] r_err_addr;

    logic        w_chk_err;
    logic        w_in_beat;
    logic        w_hs;
    logic        w_tmo;
    logic        w_err_evt;
    logic        w_to_resp;
    logic [31:0] w_b0_wdata;
    logic [3:0]  w_b0_wstrb;
    logic [31:0] w_lane;
    logic [63:0] w_rdata_next;

    assign w_chk_err = (r_addr[63:32] != 32'h0)
                     | ((r_size == 2'd1) & r_addr[0])
                     | ((r_size == 2'd2) & (r_addr[1:0] != 2'b00))
                     | ((r_size == 2'd3) & (r_addr[2:0] != 3'b000));

    assign w_in_beat = (r_state == S_BEAT0) | (r_state == S_BEAT1);
    assign w_hs      = r_pb_valid & bus.pb_ready;
    // Ready arriving in the last allowed cycle still wins over the abort.
    assign w_tmo     = r_pb_valid & ~bus.pb_ready & (r_tmo == C_TMO_LAST);
    assign w_err_evt = ((r_state == S_CHECK) & w_chk_err)
                     | (w_in_beat & ((w_hs & bus.pb_err) | w_tmo));

    // Every exit into RESP; only a clean dword beat0 continues to BEAT1.
    assign w_to_resp = ((r_state == S_CHECK) & w_chk_err)
                     | (w_in_beat & (w_tmo | (w_hs & (bus.pb_err
                         | ~((r_state == S_BEAT0) & (r_size == 2'd3))))));

    // Beat0 write lanes: narrow data is replicated so any lane can pick it.
    always_comb begin
        w_b0_wdata = r_wdata[31:0];
        w_b0_wstrb = 4'hF;
        case (r_size)
            2'd0: begin
                w_b0_wdata = {4{r_wdata[7:0]}};
                w_b0_wstrb = 4'b0001 << r_addr[1:0];
            end
            2'd1: begin
                w_b0_wdata = {2{r_wdata[15:0]}};
                w_b0_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Read lane select: shift the addressed bytes down and zero-extend.
    always_comb begin
        w_lane = bus.pb_rdata;
        case (r_size)
            2'd0: begin
                case (r_addr[1:0])
                    2'd0:    w_lane = {24'h0, bus.pb_rdata[7:0]};
                    2'd1:    w_lane = {24'h0, bus.pb_rdata[15:8]};
                    2'd2:    w_lane = {24'h0, bus.pb_rdata[23:16]};
                    default: w_lane = {24'h0, bus.pb_rdata[31:24]};
                endcase
            end
            2'd1:    w_lane = r_addr[1] ? {16'h0, bus.pb_rdata[31:16]}
                                        : {16'h0, bus.pb_rdata[15:0]};
            default: ;
        endcase
    end

    assign w_rdata_next = (r_state == S_BEAT1) ? {bus.pb_rdata, r_rdata_lo}
                                               : {32'h0, w_lane};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wen       <= 1'b0;
            r_size      <= 2'd0;
            r_rdata_lo  <= '0;
            r_tmo       <= '0;
            r_pb_valid  <= 1'b0;
            r_pb_addr   <= '0;
            r_pb_write  <= 1'b0;
            r_pb_wdata  <= '0;
            r_pb_wstrb  <= 4'h0;
            r_ext_ack   <= 1'b0;
            r_ext_rdata <= '0;
        end else begin
            // ack and rdata are only non-zero for the single RESP cycle
            r_ext_ack   <= 1'b0;
            r_ext_rdata <= '0;
            if (w_to_resp) begin
                r_state     <= S_RESP;
                r_pb_valid  <= 1'b0;
                r_pb_addr   <= '0;
                r_pb_write  <= 1'b0;
                r_pb_wdata  <= '0;
                r_pb_wstrb  <= 4'h0;
                r_ext_ack   <= 1'b1;
                if (r_wen)
                    r_ext_rdata <= '0;
                else if (w_err_evt)
                    r_ext_rdata <= ERR_RDATA;
                else
                    r_ext_rdata <= w_rdata_next;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.ext_req) begin
                            r_addr     <= bus.ext_addr;
                            r_wdata    <= bus.ext_wdata;
                            r_wen      <= bus.ext_wen;
                            r_size     <= bus.ext_size;
                            r_rdata_lo <= '0;
                            r_state    <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        r_state    <= S_BEAT0;
                        r_pb_valid <= 1'b1;
                        r_pb_addr  <= {r_addr[31:2], 2'b00};
                        r_pb_write <= r_wen;
                        r_pb_wdata <= w_b0_wdata;
                        r_pb_wstrb <= r_wen ? w_b0_wstrb : 4'h0;
                        r_tmo      <= '0;
                    end
                    S_BEAT0, S_BEAT1: begin
                        if (w_hs) begin
                            // Only a clean dword beat0 lands here.
                            r_rdata_lo <= w_rdata_next[31:0];
                            r_state    <= S_BEAT1;
                            r_pb_addr  <= r_pb_addr + 32'd4;
                            r_pb_wdata <= r_wdata[63:32];
                            r_pb_wstrb <= r_wen ? 4'hF : 4'h0;
                            r_tmo      <= '0;
                        end else begin
                            r_tmo <= r_tmo + 16'd1;
                        end
                    end
                    S_RESP:  r_state <= S_GAP;
                    S_GAP:   r_state <= S_IDLE;  // requester still deasserting
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Sticky error capture; a same-cycle clear discards the new error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_flag <= 1'b0;
            r_err_addr <= '0;
        end else if (err_clr) begin
            r_err_flag <= 1'b0;
            r_err_addr <= '0;
        end else if (w_err_evt) begin
            r_err_flag <= 1'b1;
            if (!r_err_flag)
                r_err_addr <= r_addr;
        end
    end

    assign bus.pb_valid  = r_pb_valid;
    assign bus.pb_addr   = r_pb_addr;
    assign bus.pb_write  = r_pb_write;
    assign bus.pb_wdata  = r_pb_wdata;
    assign bus.pb_wstrb  = r_pb_wstrb;
    assign bus.ext_ack   = r_ext_ack;
    assign bus.ext_rdata = r_ext_rdata;
    assign err_flag      = r_err_flag;
    assign err_addr      = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_mp64_extbridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mp64_extbridge
//  Description : Directed, self-checking bench for mp64_extbridge. A request
//                is launched at a falling edge (as if registered by the
//                requester at edge N); all outputs are observed on falling
//                edges, and cycle index k means "after rising edge N+k".
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mp64_extbridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        err_clr;
    logic        err_flag;
    logic [63:0] err_addr;

    mp64_extbridge_if bus ();

    mp64_extbridge #(
        .TIMEOUT_CYCLES (64),
        .ERR_RDATA      (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .err_clr  (err_clr),
        .err_flag (err_flag),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;

    // per-transaction observations
    int          nbeats;
    int          nacks;
    int          valid_cycles;
    int          first_valid;
    int          ack_cycle;
    logic [63:0] ack_rdata;
    logic [31:0] lg_addr  [4];
    logic [31:0] lg_wdata [4];
    logic [3:0]  lg_wstrb [4];
    logic        lg_write [4];
    logic [31:0] rd       [2];   // pb_rdata returned for beat 0 / beat 1

    // Drives one request and plays the pbus slave.
    // mode 0: pb_ready tied high, mode 1: pb_ready held low.
    // err_beat: beat index answered with pb_err (-1 none).
    // clr_cyc: cycle index during which err_clr is high (-1 none).
    task automatic run_txn(input logic [63:0] a, input logic [63:0] wd,
                           input logic we, input logic [1:0] sz,
                           input int target_acks, input int mode,
                           input int err_beat, input int clr_cyc);
        int cyc;
        int tail;
        nbeats = 0; nacks = 0; valid_cycles = 0;
        first_valid = -1; ack_cycle = -1; ack_rdata = '0;
        bus.ext_addr  = a;
        bus.ext_wdata = wd;
        bus.ext_wen   = we;
        bus.ext_size  = sz;
        bus.ext_req   = 1'b1;
        cyc  = 0;
        tail = -1;
        while (tail != 0 && cyc < 300) begin
            if (bus.ext_ack) begin
                nacks++;
                ack_rdata = bus.ext_rdata;
                ack_cycle = cyc;
                if (nacks >= target_acks && tail < 0) begin
                    bus.ext_req = 1'b0;
                    tail = 4;
                end
            end
            if (bus.pb_valid) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = cyc;
            end
            err_clr      = (cyc == clr_cyc);
            bus.pb_ready = (mode == 0);
            bus.pb_rdata = (nbeats < 2) ? rd[nbeats] : 32'h0;
            bus.pb_err   = (nbeats == err_beat);
            if (bus.pb_valid && bus.pb_ready) begin
                if (nbeats < 4) begin
                    lg_addr[nbeats]  = bus.pb_addr;
                    lg_wdata[nbeats] = bus.pb_wdata;
                    lg_wstrb[nbeats] = bus.pb_wstrb;
                    lg_write[nbeats] = bus.pb_write;
                end
                nbeats++;
            end
            if (tail > 0) tail--;
            @(negedge clk);
            cyc++;
        end
        err_clr      = 1'b0;
        bus.ext_req  = 1'b0;
        bus.pb_ready = 1'b0;
        bus.pb_err   = 1'b0;
        if (tail != 0) begin
            errors++;
            $display("FAIL txn_budget: no ack within 300 cycles for addr %h", a);
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; err_clr = 1'b0;
        bus.ext_req = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
        bus.ext_wen = 1'b0; bus.ext_size = 2'd0;
        bus.pb_ready = 1'b0; bus.pb_rdata = '0; bus.pb_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.pb_valid !== 1'b0) begin errors++; $display("FAIL rst_pb_valid: got %b expected 0", bus.pb_valid); end
        checks++; if (bus.ext_ack !== 1'b0) begin errors++; $display("FAIL rst_ext_ack: got %b expected 0", bus.ext_ack); end
        checks++; if (bus.ext_rdata !== 64'h0) begin errors++; $display("FAIL rst_ext_rdata: got %h expected 0", bus.ext_rdata); end
        checks++; if (err_flag !== 1'b0 || err_addr !== 64'h0) begin errors++; $display("FAIL rst_err: got %b/%h expected 0/0", err_flag, err_addr); end
        checks++; if (bus.pb_addr !== 32'h0 || bus.pb_wstrb !== 4'h0) begin errors++; $display("FAIL rst_pb_bus: got %h/%h expected 0/0", bus.pb_addr, bus.pb_wstrb); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_word_read();
        rd[0] = 32'hE00E_0A10; rd[1] = 32'h0;
        run_txn(64'h8000_0000, 64'h0, 1'b0, 2'd2, 1, 0, -1, -1);
        checks++; if (nbeats !== 1) begin errors++; $display("FAIL wrd_nbeats: got %0d expected 1", nbeats); end
        checks++; if (lg_addr[0] !== 32'h8000_0000 || lg_wstrb[0] !== 4'h0 || lg_write[0] !== 1'b0) begin errors++; $display("FAIL wrd_beat: got %h/%h/%b expected 80000000/0/0", lg_addr[0], lg_wstrb[0], lg_write[0]); end
        checks++; if (first_valid !== 2) begin errors++; $display("FAIL wrd_valid_latency: got %0d expected 2", first_valid); end
        checks++; if (ack_cycle !== 3 || nacks !== 1) begin errors++; $display("FAIL wrd_ack: got cycle %0d count %0d expected 3/1", ack_cycle, nacks); end
        checks++; if (ack_rdata !== 64'h0000_0000_E00E_0A10) begin errors++; $display("FAIL wrd_rdata: got %h expected 00000000e00e0a10", ack_rdata); end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL wrd_err_flag: got %b expected 0", err_flag); end
    endtask

    task automatic test_dword_write();
        run_txn(64'h8000_0010, 64'h1122_3344_5566_7788, 1'b1, 2'd3, 1, 0, -1, -1);
        checks++; if (nbeats !== 2 || nacks !== 1) begin errors++; $display("FAIL dw_counts: got beats %0d acks %0d expected 2/1", nbeats, nacks); end
        checks++; if (lg_addr[0] !== 32'h8000_0010 || lg_wdata[0] !== 32'h5566_7788 || lg_wstrb[0] !== 4'hF || lg_write[0] !== 1'b1) begin errors++; $display("FAIL dw_beat0: got %h/%h/%h/%b expected 80000010/55667788/f/1", lg_addr[0], lg_wdata[0], lg_wstrb[0], lg_write[0]); end
        checks++; if (lg_addr[1] !== 32'h8000_0014 || lg_wdata[1] !== 32'h1122_3344 || lg_wstrb[1] !== 4'hF) begin errors++; $display("FAIL dw_beat1: got %h/%h/%h expected 80000014/11223344/f", lg_addr[1], lg_wdata[1], lg_wstrb[1]); end
        checks++; if (ack_cycle !== 4 || ack_rdata !== 64'h0) begin errors++; $display("FAIL dw_ack: got cycle %0d rdata %h expected 4/0", ack_cycle, ack_rdata); end
    endtask

    task automatic test_narrow();
        // byte write to lane 3
        run_txn(64'h8000_0003, 64'h0000_0000_0000_00AB, 1'b1, 2'd0, 1, 0, -1, -1);
        checks++; if (lg_addr[0] !== 32'h8000_0000 || lg_wstrb[0] !== 4'b1000 || lg_wdata[0] !== 32'hABAB_ABAB) begin errors++; $display("FAIL bwr_beat: got %h/%h/%h expected 80000000/8/abababab", lg_addr[0], lg_wstrb[0], lg_wdata[0]); end
        // half read from upper half
        rd[0] = 32'hBEEF_0000;
        run_txn(64'h8000_0006, 64'h0, 1'b0, 2'd1, 1, 0, -1, -1);
        checks++; if (lg_addr[0] !== 32'h8000_0004 || lg_wstrb[0] !== 4'h0) begin errors++; $display("FAIL hrd_beat: got %h/%h expected 80000004/0", lg_addr[0], lg_wstrb[0]); end
        checks++; if (ack_rdata !== 64'h0000_0000_0000_BEEF) begin errors++; $display("FAIL hrd_rdata: got %h expected 000000000000beef", ack_rdata); end
        // byte read from lane 1
        rd[0] = 32'h1122_3344;
        run_txn(64'h8000_0001, 64'h0, 1'b0, 2'd0, 1, 0, -1, -1);
        checks++; if (ack_rdata !== 64'h0000_0000_0000_0033) begin errors++; $display("FAIL brd_rdata: got %h expected 0000000000000033", ack_rdata); end
        // half write to upper half
        run_txn(64'h8000_0002, 64'h0000_0000_0000_CAFE, 1'b1, 2'd1, 1, 0, -1, -1);
        checks++; if (lg_wstrb[0] !== 4'b1100 || lg_wdata[0] !== 32'hCAFE_CAFE) begin errors++; $display("FAIL hwr_beat: got %h/%h expected c/cafecafe", lg_wstrb[0], lg_wdata[0]); end
        // dword read assembly
        rd[0] = 32'hAAAA_0001; rd[1] = 32'hBBBB_0002;
        run_txn(64'h8000_0018, 64'h0, 1'b0, 2'd3, 1, 0, -1, -1);
        checks++; if (ack_rdata !== 64'hBBBB_0002_AAAA_0001 || nbeats !== 2) begin errors++; $display("FAIL dwrd_rdata: got %h beats %0d expected bbbb0002aaaa0001/2", ack_rdata, nbeats); end
    endtask

    task automatic test_errors();
        run_txn(64'h8000_0002, 64'h0, 1'b0, 2'd2, 1, 0, -1, -1);
        checks++; if (valid_cycles !== 0 || nacks !== 1) begin errors++; $display("FAIL mis_no_beat: got valid %0d acks %0d expected 0/1", valid_cycles, nacks); end
        checks++; if (ack_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mis_rdata: got %h expected all ones", ack_rdata); end
        checks++; if (err_flag !== 1'b1 || err_addr !== 64'h8000_0002) begin errors++; $display("FAIL mis_capture: got %b/%h expected 1/80000002", err_flag, err_addr); end
        run_txn(64'h1_0000_0000, 64'h0, 1'b0, 2'd3, 1, 0, -1, -1);
        checks++; if (valid_cycles !== 0 || ack_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL hi_addr: got valid %0d rdata %h expected 0/all ones", valid_cycles, ack_rdata); end
        checks++; if (err_flag !== 1'b1 || err_addr !== 64'h8000_0002) begin errors++; $display("FAIL err_addr_keep: got %b/%h expected 1/80000002", err_flag, err_addr); end
        run_txn(64'h8000_0001, 64'h1234, 1'b1, 2'd1, 1, 0, -1, -1);
        checks++; if (valid_cycles !== 0 || ack_rdata !== 64'h0) begin errors++; $display("FAIL mis_write: got valid %0d rdata %h expected 0/0", valid_cycles, ack_rdata); end
        pulse_clr();
        checks++; if (err_flag !== 1'b0 || err_addr !== 64'h0) begin errors++; $display("FAIL err_clr: got %b/%h expected 0/0", err_flag, err_addr); end
        // clear coincides with the error set at the CHECK edge
        run_txn(64'h8000_0004, 64'h0, 1'b0, 2'd3, 1, 0, -1, 1);
        checks++; if (err_flag !== 1'b0 || err_addr !== 64'h0) begin errors++; $display("FAIL clr_priority: got %b/%h expected 0/0", err_flag, err_addr); end
        // slave error on beat0 of a dword read stops after one beat
        rd[0] = 32'h0; rd[1] = 32'h0;
        run_txn(64'h8000_0030, 64'h0, 1'b0, 2'd3, 1, 0, 0, -1);
        checks++; if (nbeats !== 1 || ack_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL slv_err: got beats %0d rdata %h expected 1/all ones", nbeats, ack_rdata); end
        checks++; if (err_flag !== 1'b1 || err_addr !== 64'h8000_0030) begin errors++; $display("FAIL slv_err_capture: got %b/%h expected 1/80000030", err_flag, err_addr); end
        pulse_clr();
    endtask

    task automatic test_timeout();
        run_txn(64'h8000_0020, 64'h0, 1'b0, 2'd2, 1, 1, -1, -1);
        checks++; if (valid_cycles !== 64) begin errors++; $display("FAIL tmo_valid_cycles: got %0d expected 64", valid_cycles); end
        checks++; if (ack_cycle !== 66 || ack_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL tmo_ack: got cycle %0d rdata %h expected 66/all ones", ack_cycle, ack_rdata); end
        checks++; if (err_flag !== 1'b1 || err_addr !== 64'h8000_0020) begin errors++; $display("FAIL tmo_capture: got %b/%h expected 1/80000020", err_flag, err_addr); end
        pulse_clr();
        rd[0] = 32'h1234_5678;
        run_txn(64'h8000_0024, 64'h0, 1'b0, 2'd2, 1, 0, -1, -1);
        checks++; if (ack_rdata !== 64'h0000_0000_1234_5678 || err_flag !== 1'b0) begin errors++; $display("FAIL tmo_recover: got %h/%b expected 0000000012345678/0", ack_rdata, err_flag); end
    endtask

    task automatic test_back_to_back();
        rd[0] = 32'h0000_00C1; rd[1] = 32'h0000_00C2;
        // req stays high across the first ack and GAP; dropped at the second ack
        run_txn(64'h8000_0040, 64'h0, 1'b0, 2'd2, 2, 0, -1, -1);
        checks++; if (nacks !== 2 || nbeats !== 2) begin errors++; $display("FAIL held_req: got acks %0d beats %0d expected 2/2", nacks, nbeats); end
        checks++; if (ack_cycle !== 8 || ack_rdata !== 64'h0000_0000_0000_00C2) begin errors++; $display("FAIL held_req_second: got cycle %0d rdata %h expected 8/c2", ack_cycle, ack_rdata); end
    endtask

    task automatic test_reset_mid_beat1();
        int found;
        int late_acks;
        found = 0;
        late_acks = 0;
        bus.ext_addr = 64'h8000_0040; bus.ext_wdata = 64'h0;
        bus.ext_wen = 1'b0; bus.ext_size = 2'd3;
        bus.ext_req = 1'b1; bus.pb_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.pb_valid && bus.pb_addr == 32'h8000_0044) begin
                found = 1;
                break;
            end
        end
        bus.pb_ready = 1'b0;
        bus.ext_req  = 1'b0;
        checks++; if (found !== 1) begin errors++; $display("FAIL rst_mid_reach_beat1: got %0d expected 1", found); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.pb_valid !== 1'b0 || bus.ext_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got valid %b ack %b expected 0/0", bus.pb_valid, bus.ext_ack); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.ext_ack || bus.pb_valid) late_acks++;
        end
        checks++; if (late_acks !== 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d busy cycles expected 0", late_acks); end
        rd[0] = 32'h0BAD_F00D;
        run_txn(64'h8000_0048, 64'h0, 1'b0, 2'd2, 1, 0, -1, -1);
        checks++; if (ack_rdata !== 64'h0000_0000_0BAD_F00D || nacks !== 1) begin errors++; $display("FAIL rst_mid_recover: got %h acks %0d expected 000000000badf00d/1", ack_rdata, nacks); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rd[0] = 32'h0; rd[1] = 32'h0;
        @(negedge clk);
        test_reset();
        test_word_read();
        test_dword_write();
        test_narrow();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid_beat1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mp64_extbridge.md
Name: mp64_extbridge

Overview:
- Downstream consumer of the memory subsystem's external-forward port (ext_* request/ack interface).
- Converts each held 64-bit ext request into one or two beats on a 32-bit valid/ready peripheral bus (pbus).
- Adds alignment checking, a per-beat timeout and error capture, so accesses outside all banks always terminate.

Parameters:
- TIMEOUT_CYCLES, 64, cycles a beat may wait for pb_ready before it is aborted as an error (1..65535).
- ERR_RDATA, 64'hFFFF_FFFF_FFFF_FFFF, value returned on ext_rdata for any errored read.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ext_req  in  1  request from the memory subsystem, held until ext_ack.
- ext_addr  in  64  byte address.
- ext_wdata  in  64  write data, right-justified for sub-dword sizes.
- ext_wen  in  1  1 = write, 0 = read.
- ext_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- ext_rdata  out  64  read data, right-justified and zero-extended; valid while ext_ack=1.
- ext_ack  out  1  one-cycle completion pulse.
- pb_valid  out  1  beat valid.
- pb_addr  out  32  word-aligned beat address (low 2 bits = 0).
- pb_write  out  1  beat is a write.
- pb_wdata  out  32  lane-positioned write data.
- pb_wstrb  out  4  byte strobes; 0 on reads.
- pb_ready  in  1  beat accepted/completed this cycle.
- pb_rdata  in  32  read data, sampled when pb_valid && pb_ready.
- pb_err  in  1  slave error, sampled with pb_ready.
- err_flag  out  1  sticky error indicator.
- err_addr  out  64  ext_addr of the first errored request since the last clear.
- err_clr  in  1  synchronous clear of err_flag and err_addr.

Behaviour:
- Reset: all outputs are 0 (err_addr=0, ext_rdata=0); FSM goes to IDLE; the beat counter and timeout counter are cleared. Reset mid-transfer drops pb_valid immediately and no ack is issued.
- FSM states: IDLE, CHECK, BEAT0, BEAT1, RESP, GAP.
- IDLE: on ext_req=1, latch addr, wdata, wen and size, then go to CHECK.
- CHECK (one cycle), error conditions:
  - ext_addr[63:32] != 0;
  - half with addr[0] set;
  - word with addr[1:0] != 0;
  - dword with addr[2:0] != 0.
  - On any error: go to RESP with error set. Otherwise go to BEAT0.
- BEAT0: pb_valid=1, pb_addr={addr[31:2],2'b00}.
  - Byte: wstrb=1<<addr[1:0]; wdata byte replicated on all lanes.
  - Half: wstrb=addr[1]?4'b1100:4'b0011; halfword replicated.
  - Word/dword: wstrb=4'hF, wdata=low 32 bits.
  - Outputs stay stable until pb_ready.
  - On pb_ready with pb_err: go to RESP with error.
  - On pb_ready, dword: go to BEAT1. Otherwise go to RESP.
- BEAT1: pb_addr = beat0 address + 4, wdata = high 32 bits, wstrb=4'hF. Same exit rules as BEAT0.
- Read assembly: the selected lane is shifted to bit 0 and zero-extended. For dword, beat0 fills [31:0] and beat1 fills [63:32].
- Timeout:
  - The counter resets on entry to each beat.
  - If pb_ready is still low after TIMEOUT_CYCLES cycles of pb_valid, pb_valid is dropped and the FSM goes to RESP with error.
- RESP: ext_ack=1 for exactly one cycle. ext_rdata is the assembled data, or ERR_RDATA on an errored read; it is 0 on writes. Then go to GAP.
- GAP: one cycle in which ext_req is ignored (the requester is still deasserting), then IDLE.
  - A req still high in the cycle after GAP starts a new transaction.
- Error capture: on any error, err_flag is set. err_addr is loaded only if err_flag was 0.
  - err_clr has priority over a same-cycle error set; that error is lost.
- Latency:
  - Aligned word read with pb_ready tied high: ext_req sampled at edge N, pb_valid from N+2, ack pulse after edge N+3.
  - Dword adds one cycle.
- An errored write never modifies pbus state beyond beats already accepted. A beat1 error after a beat0 write is not rolled back.

Test Plan:
- Word read at 0x8000_0000, slave ready in 1 cycle with pb_rdata=0xE00E_0A10 -> one beat with pb_addr=0x8000_0000, wstrb=0; ext_ack pulse with ext_rdata=0x0000_0000_E00E_0A10; err_flag=0.
- Dword write of 0x1122_3344_5566_7788 to 0x8000_0010 -> beat0 to 0x8000_0010 with data 0x5566_7788, beat1 to 0x8000_0014 with data 0x1122_3344, wstrb=F both; single ack.
- Byte write of 0xAB to 0x8000_0003 -> wstrb=4'b1000, pb_wdata=0xABAB_ABAB. Half read at 0x8000_0006 with pb_rdata=0xBEEF_0000 -> ext_rdata=0xBEEF.
- Misaligned word read at 0x8000_0002 -> no pb_valid ever; ext_ack with ext_rdata=all-ones; err_flag=1, err_addr=0x8000_0002. A following error at 0x1_0000_0000 leaves err_addr unchanged; err_clr zeroes both.
- pb_ready held low, TIMEOUT_CYCLES=64 -> pb_valid drops after 64 cycles; ack with ERR_RDATA. A later normal read succeeds.
- ext_req held high through ack and GAP -> exactly one pbus transaction per ack. Reset asserted mid-BEAT1 -> pb_valid=0 and ext_ack=0 immediately.
